comparador_serial: RTL and testbench

Bit-serial signed comparator: the serial receiving end of the team's parallel signed comparator. It accepts two two's-complement operands as parallel bit pairs, MSB first, one pair per accepted beat. It produces the same `igual`/`mayor`/`menor` flags plus a one-cycle `valido` strobe. It sits behind serial links and shift-register front ends where both operands arrive a bit at a time.

---
 rtl/comparador_pkg.sv | 21 ++
 rtl/comparador_serial_decisor_bit.sv | 22 ++
 rtl/comparador_serial.sv | 106 ++++++++++
 tb/tb_comparador_serial.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/comparador_pkg.sv
// Shared types for the bit-serial signed comparator: FSM states, the
// running decision and the bit-counter width helper.
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECIBIR = 2'd1,
    FIN     = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    INDECISO = 2'd0,
    MAYOR    = 2'd1,
    MENOR    = 2'd2
  } decision_t;

  function automatic int ancho_cnt(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/comparador_serial_decisor_bit.sv
// Combinational decision step: folds one MSB-first bit pair into the
// running decision. Only the first differing pair can change it.
module decisor_bit
  import comparador_pkg::*;
(
  input  logic      bit_a,
  input  logic      bit_b,
  input  logic      es_signo,
  input  decision_t actual,
  output decision_t siguiente
);

  always_comb begin
    siguiente = actual;
    if (actual == INDECISO && bit_a != bit_b) begin
      // On the sign bit a set bit means negative, so the sense flips.
      if (es_signo) siguiente = bit_a ? MENOR : MAYOR;
      else          siguiente = bit_a ? MAYOR : MENOR;
    end
  end

endmodule

// File: rtl/comparador_serial.sv
// Bit-serial signed comparator, operands arrive MSB first as bit pairs.
// Optional macro COMPARADOR_SERIAL_EARLY_EN: finish as soon as decided.
module comparador_serial
  import comparador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inicio,
  input  logic bit_valido,
  input  logic bit_a,
  input  logic bit_b,
  output logic ocupado,
  output logic valido,
  output logic igual,
  output logic mayor,
  output logic menor
);

  localparam int CW = ancho_cnt(WIDTH);
  localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

  estado_t        state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  decision_t      dec_reg, dec_next;
  decision_t      dec_bit;
  logic           igual_reg, igual_next;
  logic           mayor_reg, mayor_next;
  logic           menor_reg, menor_next;
  logic           fin_palabra;

  decisor_bit u_decisor (
    .bit_a     (bit_a),
    .bit_b     (bit_b),
    .es_signo  (cnt_reg == '0),
    .actual    (dec_reg),
    .siguiente (dec_bit)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dec_next    = dec_reg;
    igual_next  = igual_reg;
    mayor_next  = mayor_reg;
    menor_next  = menor_reg;
    fin_palabra = 1'b0;
    if (inicio) begin
      // A pair presented together with inicio is deliberately dropped.
      state_next = RECIBIR;
      cnt_next   = '0;
      dec_next   = INDECISO;
      igual_next = 1'b0;
      mayor_next = 1'b0;
      menor_next = 1'b0;
    end else begin
      case (state_reg)
        RECIBIR: begin
          if (bit_valido) begin
            dec_next = dec_bit;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == ULTIMO) fin_palabra = 1'b1;
`ifdef COMPARADOR_SERIAL_EARLY_EN
            if (dec_bit != INDECISO) fin_palabra = 1'b1;
`endif
            if (fin_palabra) begin
              state_next = FIN;
              igual_next = (dec_bit == INDECISO);
              mayor_next = (dec_bit == MAYOR);
              menor_next = (dec_bit == MENOR);
            end
          end
        end
        FIN:     state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dec_reg   <= INDECISO;
      igual_reg <= 1'b0;
      mayor_reg <= 1'b0;
      menor_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dec_reg   <= dec_next;
      igual_reg <= igual_next;
      mayor_reg <= mayor_next;
      menor_reg <= menor_next;
    end
  end

  // Status outputs decode the state register only, so no input reaches them.
  assign ocupado = (state_reg == RECIBIR);
  assign valido  = (state_reg == FIN);
  assign igual   = igual_reg;
  assign mayor   = mayor_reg;
  assign menor   = menor_reg;

endmodule

// File: tb/tb_comparador_serial.sv
// Randomized self-checking bench for comparador_serial against a signed
// arithmetic reference model; honours COMPARADOR_SERIAL_EARLY_EN.
module tb_comparador_serial;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n, inicio, bit_valido, bit_a, bit_b;
  logic ocupado, valido, igual, mayor, menor;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_igual, exp_mayor, exp_menor;

  always #5 clk = ~clk;

  comparador_serial #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inicio     (inicio),
    .bit_valido (bit_valido),
    .bit_a      (bit_a),
    .bit_b      (bit_b),
    .ocupado    (ocupado),
    .valido     (valido),
    .igual      (igual),
    .mayor      (mayor),
    .menor      (menor)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pairs the DUT must consume before reporting a result.
  function automatic int pares_esperados(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMPARADOR_SERIAL_EARLY_EN
    for (int i = WIDTH - 1; i >= 0; i--)
      if (a[i] != b[i]) return WIDTH - i;
`endif
    return WIDTH;
  endfunction

  task automatic modelo(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_igual = ($signed(a) == $signed(b));
    exp_mayor = ($signed(a) >  $signed(b));
    exp_menor = ($signed(a) <  $signed(b));
  endtask

  // Caller has inicio asserted at the current negedge.
  task automatic feed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int gap, input bit chain);
    int  sent;
    bit  seen;
    int  k_exp;
    sent  = 0;
    seen  = 0;
    k_exp = pares_esperados(a, b);
    modelo(a, b);
    for (int cyc = 0; cyc < 20 * WIDTH && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        inicio = 1'b0;
        check("ocupado_up", ocupado, 1'b1);
      end
      if (valido) begin
        seen = 1;
        check("pairs_at_valido", sent, k_exp);
        check("igual", igual, exp_igual);
        check("mayor", mayor, exp_mayor);
        check("menor", menor, exp_menor);
        check("ocupado_fin", ocupado, 1'b0);
        $display("a=%02h b=%02h gap=%0d -> igual=%b mayor=%b menor=%b after %0d pairs",
                 a, b, gap, igual, mayor, menor, sent);
        bit_valido = 1'b0;
        if (chain) begin
          inicio = 1'b1;
          bit_valido = 1'b1;
        end
      end else if (sent < WIDTH && int'($urandom_range(99)) >= gap) begin
        bit_valido = 1'b1;
        bit_a = a[WIDTH-1-sent];
        bit_b = b[WIDTH-1-sent];
        sent++;
      end else begin
        bit_valido = 1'b0;
        bit_a = 1'($urandom);
        bit_b = 1'($urandom);
      end
    end
    if (!seen) check("valido_timeout", 0, 1);
    if (!chain) begin
      @(negedge clk);
      check("strobe_once", valido, 1'b0);
      check("ocupado_idle", ocupado, 1'b0);
      check("hold_flags", {igual, mayor, menor}, {exp_igual, exp_mayor, exp_menor});
    end
  endtask

  task automatic compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int gap);
    @(negedge clk);
    inicio = 1'b1;
    bit_valido = 1'b1;
    bit_a = 1'($urandom);
    bit_b = 1'($urandom);
    feed(a, b, gap, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, wa, wb;
    int strobes;
    rst_n = 1'b0; inicio = 1'b0; bit_valido = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {ocupado, valido, igual, mayor, menor}, 5'b0);
    rst_n = 1'b1;

    compare(8'h05, 8'h03, 0);
    compare(8'hFF, 8'h01, 0);
    compare(8'h80, 8'h7F, 0);
    compare(8'h5A, 8'h5A, 50);

    // bit_valido while idle must not disturb anything
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_valido = 1'b1; bit_a = 1'($urandom); bit_b = 1'($urandom);
      if (i > 0) check("idle_ignore", {ocupado, valido, igual, mayor, menor},
                       {2'b00, exp_igual, exp_mayor, exp_menor});
    end

    // reset in the middle of an equal word
    wa = 8'h5A;
    @(negedge clk); inicio = 1'b1; bit_valido = 1'b0;
    @(negedge clk); inicio = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valido = 1'b1; bit_a = wa[WIDTH-1-i]; bit_b = wa[WIDTH-1-i];
      @(negedge clk);
    end
    rst_n = 1'b0; bit_valido = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("mid_reset", {ocupado, valido, igual, mayor, menor}, 5'b0);
    @(negedge clk);
    check("post_reset_idle", {ocupado, valido, igual, mayor, menor}, 5'b0);
    compare(8'h10, 8'h20, 0);

    // abort after 5 pairs of a word, then a full word
    wa = 8'h7F; wb = 8'h00; strobes = 0;
    @(negedge clk); inicio = 1'b1; bit_valido = 1'b0;
    @(negedge clk); inicio = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valido = 1'b1; bit_a = wa[WIDTH-1-i]; bit_b = wb[WIDTH-1-i];
      @(negedge clk);
      if (valido) strobes++;
    end
    check("aborted_strobes", strobes, (pares_esperados(wa, wb) <= 5) ? 1 : 0);
    inicio = 1'b1; bit_valido = 1'b0;
    feed(8'h00, 8'h01, 0, 0);

    // back-to-back: inicio during FIN
    @(negedge clk); inicio = 1'b1; bit_valido = 1'b0;
    feed(8'h3C, 8'hC3, 10, 1);
    feed(8'hC3, 8'h3C, 10, 0);

    // random words, some forced equal
    for (int n = 0; n < 30; n++) begin
      ra = WIDTH'($urandom);
      rb = (n % 5 == 0) ? ra : WIDTH'($urandom);
      if (n % 7 == 0) rb = ra ^ WIDTH'(1 << $urandom_range(WIDTH - 1));
      compare(ra, rb, int'($urandom_range(60)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
